// File: rtl/decode_fetch_ctrl_if.sv
// Bundle of signals between the fetch/decode-window controller, the I-cache
// and decode stage 1. The controller uses the master view; the cache and the
// decode stage (or a testbench) use the slave view.
interface decode_fetch_ctrl_if;
  logic         redirect;
  logic [31:0]  redirect_eip;
  logic         fetch_req;
  logic [31:0]  fetch_addr;
  logic         fetch_ack;
  logic [127:0] fetch_data;
  logic [127:0] ir_out;
  logic         ir_valid;
  logic         de_stall;
  logic [3:0]   instr_length_updt;
  logic [31:0]  cur_eip;

  modport master (
    input  redirect, redirect_eip, fetch_ack, fetch_data, de_stall, instr_length_updt,
    output fetch_req, fetch_addr, ir_out, ir_valid, cur_eip
  );

  modport slave (
    output redirect, redirect_eip, fetch_ack, fetch_data, de_stall, instr_length_updt,
    input  fetch_req, fetch_addr, ir_out, ir_valid, cur_eip
  );
endinterface

// File: rtl/decode_fetch_ctrl.sv
// Instruction-byte queue in front of decode stage 1. Aligned 16-byte lines
// from the I-cache fill a 32-byte circular queue made of two slots; the
// decode window is a byte rotate of the queue starting at the read pointer.
// A redirect flushes the queue and restarts fetching at the new address; the
// bytes of the first line below the start address are skipped.
module decode_fetch_ctrl #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  decode_fetch_ctrl_if.master bus
);

  typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;

  fetch_state_t state, state_next;

  logic [7:0]  queue_mem [32];
  logic [4:0]  rd_ptr;
  logic        wr_slot;
  logic [5:0]  count;
  logic [3:0]  skip;
  logic [31:0] eip;
  logic [31:0] next_line;

  logic        window_valid;
  logic        advance;
  logic [5:0]  adv_len;
  logic [5:0]  count_after_adv;
  logic        fill;
  logic [5:0]  fill_len;
  logic [5:0]  count_next;

  // The window is usable once a full 16 bytes sit in the queue; since the
  // longest instruction is 15 bytes an advance can never underflow count.
  assign window_valid    = (count >= 6'd16);
  assign advance         = window_valid && !bus.de_stall && (bus.instr_length_updt != 4'd0);
  assign adv_len         = advance ? {2'b00, bus.instr_length_updt} : 6'd0;
  assign count_after_adv = count - adv_len;
  assign fill            = (state == F_WAIT) && bus.fetch_ack && !bus.redirect;
  assign fill_len        = fill ? (6'd16 - {2'b00, skip}) : 6'd0;
  assign count_next      = count_after_adv + fill_len;

  // Fetch state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= F_IDLE;
    else       state <= state_next;
  end

  // Request a line whenever a whole slot is free after this cycle's advance;
  // keep requesting back-to-back while space still allows after a fill.
  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = F_WAIT;
    end else begin
      case (state)
        F_IDLE: if (count_after_adv <= 6'd16) state_next = F_WAIT;
        F_WAIT: if (fill) state_next = (count_next <= 6'd16) ? F_WAIT : F_IDLE;
        default: state_next = F_IDLE;
      endcase
    end
  end

  // Outputs are taken only from registers: the request from the state, the
  // window from a rotate of the queue array.
  always_comb begin
    bus.fetch_req  = (state == F_WAIT);
    bus.fetch_addr = next_line;
    bus.ir_valid   = window_valid;
    bus.cur_eip    = eip;
    bus.ir_out     = '0;
    for (int i = 0; i < 16; i++) begin
      bus.ir_out[127 - 8*i -: 8] = queue_mem[rd_ptr + 5'(i)];
    end
  end

  // Queue storage: a returned line lands in the slot selected by wr_slot,
  // lowest address first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) queue_mem[i] <= 8'h00;
    end else if (fill) begin
      for (int i = 0; i < 16; i++) begin
        queue_mem[{wr_slot, 4'(i)}] <= bus.fetch_data[127 - 8*i -: 8];
      end
    end
  end

  // Pointers, occupancy and stream addresses; a redirect restarts the stream
  // and throws away any line returned in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 6'd0;
      wr_slot   <= 1'b0;
      rd_ptr    <= {1'b0, RESET_EIP[3:0]};
      skip      <= RESET_EIP[3:0];
      eip       <= RESET_EIP;
      next_line <= {RESET_EIP[31:4], 4'h0};
    end else if (bus.redirect) begin
      count     <= 6'd0;
      wr_slot   <= 1'b0;
      rd_ptr    <= {1'b0, bus.redirect_eip[3:0]};
      skip      <= bus.redirect_eip[3:0];
      eip       <= bus.redirect_eip;
      next_line <= {bus.redirect_eip[31:4], 4'h0};
    end else begin
      count <= count_next;
      if (advance) begin
        rd_ptr <= rd_ptr + {1'b0, bus.instr_length_updt};
        eip    <= eip + {28'd0, bus.instr_length_updt};
      end
      if (fill) begin
        wr_slot   <= ~wr_slot;
        next_line <= next_line + 32'd16;
        skip      <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_decode_fetch_ctrl.sv
// Self-checking bench for decode_fetch_ctrl: a directed table walking the
// fill/advance/wrap/redirect scenarios, then a randomized run compared
// against a stream-level model (current address and end of fetched bytes).
module tb_decode_fetch_ctrl;

  localparam logic [31:0] RESET_EIP = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  decode_fetch_ctrl_if bus();

  decode_fetch_ctrl #(.RESET_EIP(RESET_EIP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        redirect;
    logic [31:0] redirect_eip;
    logic        ack;
    logic [31:0] ack_addr;
    logic [3:0]  len;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] eip;
  } vec_t;

  vec_t vecs[$];

  // Memory image seen by the cache: each byte is a function of its address.
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h10;
  endfunction

  // Sixteen consecutive bytes starting at a, lowest address in the top byte.
  function automatic logic [127:0] bytes_from(input logic [31:0] a);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = byte_at(a + 32'(i));
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      if (mismatched <= 25)
        $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic rd, input logic [31:0] reip, input logic ack,
                         input logic [31:0] aaddr, input logic [3:0] len, input logic stall,
                         input logic req, input logic [31:0] addr, input logic valid,
                         input logic [31:0] eip);
    vec_t v;
    v.redirect = rd; v.redirect_eip = reip; v.ack = ack; v.ack_addr = aaddr;
    v.len = len; v.stall = stall; v.req = req; v.addr = addr; v.valid = valid; v.eip = eip;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic rd, input logic [31:0] reip, input logic ack,
                                input logic [31:0] aaddr, input logic [3:0] len,
                                input logic stall);
    bus.redirect          = rd;
    bus.redirect_eip      = reip;
    bus.fetch_ack         = ack;
    bus.fetch_data        = ack ? bytes_from(aaddr) : 128'h0;
    bus.instr_length_updt = len;
    bus.de_stall          = stall;
  endtask

  task automatic check_output(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] eip);
    check({tag, " fetch_req"}, 128'(bus.fetch_req), 128'(req));
    if (req) check({tag, " fetch_addr"}, 128'(bus.fetch_addr), 128'(addr));
    check({tag, " ir_valid"}, 128'(bus.ir_valid), 128'(valid));
    check({tag, " cur_eip"}, 128'(bus.cur_eip), 128'(eip));
    if (valid) check({tag, " ir_out"}, bus.ir_out, bytes_from(eip));
  endtask

  initial begin
    logic [31:0] m_eip, m_fend, reip;
    logic        m_req, rd, ack, stall;
    logic [3:0]  len;
    int          avail;

    // Directed table: redirect, redirect_eip, ack, ack line, len, stall ;
    // expected fetch_req, fetch_addr, ir_valid, cur_eip after the edge.
    add_vec(0, 0, 0, 0,             0, 0,  1, 32'h1000, 0, 32'h1000);
    add_vec(0, 0, 1, 32'h1000,      0, 0,  1, 32'h1010, 1, 32'h1000);
    add_vec(0, 0, 0, 0,             3, 0,  1, 32'h1010, 0, 32'h1003);
    add_vec(0, 0, 1, 32'h1010,      5, 0,  0, 0,        1, 32'h1003);
    add_vec(0, 0, 0, 0,             5, 0,  0, 0,        1, 32'h1008);
    add_vec(0, 0, 0, 0,            15, 0,  1, 32'h1020, 0, 32'h1017);
    add_vec(0, 0, 1, 32'h1020,      0, 0,  0, 0,        1, 32'h1017);
    add_vec(0, 0, 0, 0,             7, 1,  0, 0,        1, 32'h1017);
    add_vec(0, 0, 0, 0,             7, 0,  0, 0,        1, 32'h101E);
    add_vec(0, 0, 0, 0,             4, 0,  1, 32'h1030, 0, 32'h1022);
    add_vec(0, 0, 1, 32'h1030,      0, 0,  0, 0,        1, 32'h1022);
    add_vec(0, 0, 0, 0,            14, 0,  1, 32'h1040, 1, 32'h1030);
    add_vec(0, 0, 1, 32'h1040,      7, 0,  0, 0,        1, 32'h1037);
    add_vec(0, 0, 0, 0,             8, 0,  0, 0,        1, 32'h103F);
    add_vec(0, 0, 0, 0,             1, 0,  1, 32'h1050, 1, 32'h1040);
    add_vec(0, 0, 1, 32'h1050,      0, 0,  0, 0,        1, 32'h1040);
    for (int k = 0; k < 5; k++)
      add_vec(0, 0, 0, 0,           5, 1,  0, 0,        1, 32'h1040);
    add_vec(0, 0, 0, 0,             0, 0,  0, 0,        1, 32'h1040);
    add_vec(0, 0, 0, 0,            15, 0,  0, 0,        1, 32'h104F);
    add_vec(0, 0, 0, 0,             1, 0,  1, 32'h1060, 1, 32'h1050);
    add_vec(1, 32'h2007, 1, 32'h1060, 3, 0, 1, 32'h2000, 0, 32'h2007);
    add_vec(0, 0, 1, 32'h2000,      0, 0,  1, 32'h2010, 0, 32'h2007);
    add_vec(0, 0, 1, 32'h2010,      0, 0,  0, 0,        1, 32'h2007);
    add_vec(0, 0, 0, 0,             9, 0,  1, 32'h2020, 1, 32'h2010);

    // Reset values.
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset fetch_req", 128'(bus.fetch_req), 128'(0));
    check("reset fetch_addr", 128'(bus.fetch_addr), 128'(32'h1000));
    check("reset ir_valid", 128'(bus.ir_valid), 128'(0));
    check("reset ir_out", bus.ir_out, 128'h0);
    check("reset cur_eip", 128'(bus.cur_eip), 128'(RESET_EIP));
    reset = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].redirect, vecs[i].redirect_eip, vecs[i].ack,
                     vecs[i].ack_addr, vecs[i].len, vecs[i].stall);
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("row%0d", i), vecs[i].req, vecs[i].addr,
                   vecs[i].valid, vecs[i].eip);
    end

    // Randomized run against the stream model: m_eip is the window head,
    // m_fend the address just past the last fetched line.
    m_eip  = 32'h0;
    m_fend = 32'h0;
    m_req  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rd = (c == 0) || ($urandom % 64 == 0);
      reip = $urandom;
      if ($urandom % 8 == 0) reip = 32'hFFFF_FFE0 | 32'($urandom % 32);
      ack   = (c != 0) && m_req && ($urandom % 3 != 0);
      len   = 4'($urandom % 16);
      stall = ($urandom % 4 == 0);
      apply_stimulus(rd, reip, ack, m_fend, len, stall);
      @(posedge clk);
      if (rd) begin
        m_eip  = reip;
        m_fend = {reip[31:4], 4'h0};
        m_req  = 1'b1;
      end else begin
        avail = int'(m_fend - m_eip);
        if (avail >= 16 && !stall && len != 4'd0) m_eip = m_eip + 32'(len);
        if (m_req && ack) m_fend = m_fend + 32'd16;
        if (!(m_req && !ack)) m_req = (int'(m_fend - m_eip) <= 16);
      end
      @(negedge clk);
      check_output($sformatf("rand%0d", c), m_req, m_fend,
                   int'(m_fend - m_eip) >= 16, m_eip);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_fetch_ctrl.md
# decode_fetch_ctrl

Instruction-byte queue controller in front of decode stage 1. It fetches 16-byte aligned lines from the I-cache into a 32-byte circular byte queue and presents a byte-aligned 128-bit IR window. It advances the read pointer by the instruction length that stage 1 reports, and restarts the stream on redirect (branch or exception).

## Interface
Parameters:
- RESET_EIP, 32'h0000_0000, fetch address used after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect  in  1  flush queue and restart at redirect_eip; wins over all other inputs.
- redirect_eip  in  32  new stream address.
- fetch_req  out  1  line request to I-cache.
- fetch_addr  out  32  line address, bits [3:0] always 0.
- fetch_ack  in  1  line returned this cycle; valid only while fetch_req=1.
- fetch_data  in  128  line bytes; the lowest address is in [127:120].
- ir_out  out  128  decode window; byte at cur_eip is in [127:120], ascending addresses downward.
- ir_valid  out  1  at least 16 valid bytes are queued.
- de_stall  in  1  downstream hold; no advance this cycle.
- instr_length_updt  in  4  length of the instruction at the window head (1..15).
- cur_eip  out  32  address of ir_out[127:120].

## Operation
- Storage: 32-byte array as two 16-byte slots. 5-bit read pointer rd_ptr, 5-bit line write pointer wr_slot (bit 4 only significant), 6-bit count 0..32.
- ir_out is a byte rotate of the array starting at rd_ptr, wrapping modulo 32. Bytes beyond count are don't-care, but ir_valid=0 in that case.
- ir_valid = (count >= 16).
- Advance happens when ir_valid=1, de_stall=0 and instr_length_updt!=0:
  - rd_ptr += len (mod 32), count -= len, cur_eip += len (mod 2^32).
  - A length of 0 is treated as no advance.
- Fetch FSM has two states, F_IDLE and F_WAIT.
  - F_IDLE -> F_WAIT when free space (32 - count_after_advance_this_cycle) >= 16. On entry, fetch_req=1 and fetch_addr=next_line.
  - F_WAIT holds fetch_req and fetch_addr stable until fetch_ack.
  - On fetch_ack: write fetch_data into slot wr_slot, count += 16 - skip, wr_slot toggles, next_line += 16, skip <= 0. Go to F_IDLE, or stay in F_WAIT with the new address if space still allows (back-to-back requests permitted).
- skip: byte offset to discard from the first line after reset or redirect. It equals the start address [3:0].
  - The first line is written at slot 0 with rd_ptr=skip.
- Simultaneous advance and fill in the same cycle: count_next = count - len + 16 - skip. Free space for the request decision is evaluated after the advance.
- Redirect (registered response):
  - Next edge: count=0, wr_slot=0, rd_ptr=redirect_eip[3:0], skip=redirect_eip[3:0], cur_eip=redirect_eip, next_line={redirect_eip[31:4],4'h0}.
  - The FSM goes to F_WAIT requesting next_line.
  - A fetch_ack in the redirect cycle is discarded.
  - A pending request is abandoned; the I-cache tolerates an address change on redirect.
- Reset (asynchronous): count=0, rd_ptr=RESET_EIP[3:0], skip=RESET_EIP[3:0], cur_eip=RESET_EIP, next_line=RESET_EIP aligned, wr_slot=0, FSM=F_IDLE.
  - Reset values of outputs: fetch_req=0, fetch_addr=aligned RESET_EIP, ir_valid=0, ir_out=0 (array cleared), cur_eip=RESET_EIP.
  - The first cycle after reset release enters F_WAIT.
- Overflow is impossible by construction. An advance with len > count is impossible because ir_valid requires count >= 16 > 15.

## Timing
- All outputs come from registers or from a register-only rotate. There is no combinational path from inputs to outputs.
- Reset deasserted before edge 0: fetch_req=1 after edge 0 (one-cycle F_IDLE -> F_WAIT).
- fetch_ack at cycle N: the data is visible in ir_out and ir_valid after edge N.
- Zero offset: ir_valid goes high one cycle after the first ack.
- Nonzero offset: ir_valid goes high one cycle after the second ack.
- Redirect at cycle N: fetch_req=1 with the new address after edge N; ir_valid=0 after edge N.
- Advance at edge N: the new window is shown after edge N. Stage 1 sees the next instruction one cycle later, giving sustained throughput of one instruction per cycle while lines arrive.

## Test plan
- Reset, RESET_EIP=0x1000, cache acks each request the next cycle with bytes 00..0F then 10..1F:
  - fetch_addr shows 0x1000 then 0x1010.
  - ir_valid rises after the first ack with ir_out[127:120]=00.
  - A second request issues after the first fill.
- Lengths 3,5,15 with no stall: cur_eip goes 0x1000 -> 0x1003 -> 0x1008 -> 0x1017 and ir_out[127:120] tracks the bytes. ir_valid drops whenever count < 16 and recovers on the next ack.
- Redirect to 0x2007 while a request is pending with an ack in the same cycle:
  - The ack is ignored.
  - fetch_addr=0x2000.
  - After the first ack count=9 and ir_valid=0.
  - After the second ack ir_out[127:120] is the byte at 0x2007.
- Read-pointer wrap: advance past rd_ptr=30 with len 4. rd_ptr becomes 2 and the window bytes continue contiguously across the slot boundary.
- Simultaneous events: with count=16, advance len 7 and fetch_ack in the same cycle gives count=25, and a new fetch_req is not issued until count <= 16.
- de_stall held 5 cycles and len=0 with de_stall low: rd_ptr and cur_eip unchanged, fill continues up to count=32, then fetch_req stays low.
